// File: rtl/talon_stock_sequencer.sv
// Talon/stock pile sequencer: arbitrates take/draw requests, commands the pile datapath, owns pile counters.
// Latency: request seen in IDLE at edge k -> dp_start in cycle k+1; counters/ack update on the dp_done edge.
// Backpressure: one operation in flight; draw edges latch one deep, take_req is held by requester until ack/nack.
module talon_stock_sequencer #(
  parameter int DECK_CARDS  = 24,
  parameter int MAX_RECYCLE = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setup_ready,
  input  logic [4:0] setup_count,
  input  logic       draw_req,
  input  logic       take_req,
  output logic       take_ack,
  output logic       take_nack,
  output logic       draw_nack,
  output logic       dp_start,
  output logic [1:0] dp_op,
  input  logic       dp_done,
  output logic       busy,
  output logic [4:0] talon_size,
  output logic [4:0] waste_size,
  output logic [3:0] recycle_count,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_DRAW    = 2'd0,
    OP_RECYCLE = 2'd1,
    OP_TAKE    = 2'd2
  } op_t;

  // Authoritative pile counters travel together so a single register holds them.
  typedef struct packed {
    logic [4:0] talon;
    logic [4:0] waste;
    logic [3:0] recycles;
  } piles_t;

  localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLAST    = TW'(TIMEOUT - 1);
  localparam logic [4:0]      DECK_MAX = 5'(DECK_CARDS);

  state_t        state_q, state_nxt;
  op_t           op_q, op_nxt;
  logic [TW-1:0] tcnt_q, tcnt_nxt;
  logic          pend_q, pend_nxt;
  logic          draw_prev_q;
  piles_t        piles_q, piles_nxt;
  logic          take_ack_nxt, take_nack_nxt, draw_nack_nxt, tmo_nxt;
  logic          draw_edge;
  logic          recycle_ok;
  logic          take_blocked;

  assign draw_edge  = draw_req & ~draw_prev_q;
  assign recycle_ok = (MAX_RECYCLE == 0) || (int'(piles_q.recycles) < MAX_RECYCLE);
  // A take_req still high while its own ack/nack is showing is the old request, not a new one.
  assign take_blocked = take_ack | take_nack;

  assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign dp_start      = (state_q == S_ISSUE);
  assign dp_op         = (state_q == S_ISSUE) ? op_q : OP_DRAW;
  assign talon_size    = piles_q.talon;
  assign waste_size    = piles_q.waste;
  assign recycle_count = piles_q.recycles;

  // Next-state, arbitration, counter update and response pulses.
  always_comb begin
    state_nxt     = state_q;
    op_nxt        = op_q;
    tcnt_nxt      = tcnt_q;
    pend_nxt      = pend_q;
    piles_nxt     = piles_q;
    take_ack_nxt  = 1'b0;
    take_nack_nxt = 1'b0;
    draw_nack_nxt = 1'b0;
    tmo_nxt       = 1'b0;

    if ((state_q != S_INIT) && draw_edge) begin
      pend_nxt = 1'b1;
    end

    case (state_q)
      S_INIT: begin
        pend_nxt = 1'b0;
        if (setup_ready) begin
          piles_nxt.talon    = (setup_count > DECK_MAX) ? DECK_MAX : setup_count;
          piles_nxt.waste    = 5'd0;
          piles_nxt.recycles = 4'd0;
          state_nxt          = S_IDLE;
        end
      end

      S_IDLE: begin
        if (take_req && !take_blocked) begin
          if (piles_q.waste == 5'd0) begin
            take_nack_nxt = 1'b1;
          end else begin
            op_nxt    = OP_TAKE;
            state_nxt = S_ISSUE;
          end
        end else if (pend_q) begin
          // Clearing here wins over an edge arriving in the same cycle: the latch is one deep.
          pend_nxt = 1'b0;
          if (piles_q.talon != 5'd0) begin
            op_nxt    = OP_DRAW;
            state_nxt = S_ISSUE;
          end else if ((piles_q.waste != 5'd0) && recycle_ok) begin
            op_nxt    = OP_RECYCLE;
            state_nxt = S_ISSUE;
          end else begin
            draw_nack_nxt = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        tcnt_nxt  = '0;
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (dp_done) begin
          state_nxt = S_IDLE;
          case (op_q)
            OP_DRAW: begin
              piles_nxt.talon = piles_q.talon - 5'd1;
              piles_nxt.waste = piles_q.waste + 5'd1;
            end
            OP_RECYCLE: begin
              piles_nxt.talon    = piles_q.waste;
              piles_nxt.waste    = 5'd0;
              piles_nxt.recycles = (piles_q.recycles == 4'hF) ? 4'hF : piles_q.recycles + 4'd1;
            end
            default: begin
              piles_nxt.waste = piles_q.waste - 5'd1;
              take_ack_nxt    = 1'b1;
            end
          endcase
        end else if (tcnt_q == TLAST) begin
          // Datapath never answered: abandon the operation, counters stay as they were.
          tmo_nxt   = 1'b1;
          state_nxt = S_IDLE;
          if (op_q == OP_TAKE) begin
            take_nack_nxt = 1'b1;
          end
        end else begin
          tcnt_nxt = tcnt_q + TW'(1);
        end
      end

      default: begin
        state_nxt = S_INIT;
      end
    endcase

    // Losing the deal drops everything back to INIT and forgets any queued draw.
    if (!setup_ready) begin
      state_nxt     = S_INIT;
      pend_nxt      = 1'b0;
      take_ack_nxt  = 1'b0;
      take_nack_nxt = 1'b0;
      draw_nack_nxt = 1'b0;
    end
  end

  // State, counters and response pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      op_q        <= OP_DRAW;
      tcnt_q      <= '0;
      pend_q      <= 1'b0;
      draw_prev_q <= 1'b0;
      piles_q     <= '0;
      take_ack    <= 1'b0;
      take_nack   <= 1'b0;
      draw_nack   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      op_q        <= op_nxt;
      tcnt_q      <= tcnt_nxt;
      pend_q      <= pend_nxt;
      draw_prev_q <= draw_req;
      piles_q     <= piles_nxt;
      take_ack    <= take_ack_nxt;
      take_nack   <= take_nack_nxt;
      draw_nack   <= draw_nack_nxt;
      timeout_err <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_talon_stock_sequencer.sv
// Directed bench for talon_stock_sequencer: unlimited-recycle instance plus a MAX_RECYCLE=1 instance on shared stimulus.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: the bench plays the datapath, returning dp_done on a fixed schedule or never.
module tb_talon_stock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       setup_ready;
  logic [4:0] setup_count;
  logic       draw_req;
  logic       take_req;
  logic       dp_done;

  logic       take_ack, take_nack, draw_nack, dp_start, busy, timeout_err;
  logic [1:0] dp_op;
  logic [4:0] talon_size, waste_size;
  logic [3:0] recycle_count;

  logic       b_take_ack, b_take_nack, b_draw_nack, b_dp_start, b_busy, b_timeout_err;
  logic [1:0] b_dp_op;
  logic [4:0] b_talon_size, b_waste_size;
  logic [3:0] b_recycle_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  talon_stock_sequencer #(.DECK_CARDS(24), .MAX_RECYCLE(0), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .setup_ready(setup_ready), .setup_count(setup_count),
    .draw_req(draw_req), .take_req(take_req), .take_ack(take_ack), .take_nack(take_nack),
    .draw_nack(draw_nack), .dp_start(dp_start), .dp_op(dp_op), .dp_done(dp_done),
    .busy(busy), .talon_size(talon_size), .waste_size(waste_size),
    .recycle_count(recycle_count), .timeout_err(timeout_err)
  );

  talon_stock_sequencer #(.DECK_CARDS(24), .MAX_RECYCLE(1), .TIMEOUT(15)) dut_lim (
    .clk(clk), .rst(rst), .setup_ready(setup_ready), .setup_count(setup_count),
    .draw_req(draw_req), .take_req(take_req), .take_ack(b_take_ack), .take_nack(b_take_nack),
    .draw_nack(b_draw_nack), .dp_start(b_dp_start), .dp_op(b_dp_op), .dp_done(dp_done),
    .busy(b_busy), .talon_size(b_talon_size), .waste_size(b_waste_size),
    .recycle_count(b_recycle_count), .timeout_err(b_timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for dp_start; n is the number of edges that passed.
  task automatic wait_start(output bit got, output logic [1:0] op, output int n);
    got = 1'b0;
    op  = 2'd3;
    n   = 0;
    for (int i = 0; i < 20; i++) begin
      if (dp_start) begin
        got = 1'b1;
        op  = dp_op;
        break;
      end
      step();
      n++;
    end
  endtask

  // From the ISSUE cycle: two WAIT cycles, then a dp_done pulse.
  task automatic finish_op();
    step();
    step();
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
  endtask

  task automatic do_draw();
    bit got;
    logic [1:0] op;
    int n;
    draw_req = 1'b1;
    wait_start(got, op, n);
    draw_req = 1'b0;
    if (got) finish_op();
    step();
  endtask

  task automatic setup(input logic [4:0] cnt);
    setup_ready = 1'b0;
    step();
    setup_count = cnt;
    setup_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; setup_ready = 1'b1; setup_count = 5'd24;
    draw_req = 1'b0; take_req = 1'b0; dp_done = 1'b0;
    repeat (3) step();
    checks++; if ({talon_size, waste_size, recycle_count} !== 14'd0) begin errors++; $display("FAIL reset_counters: got %h want 0", {talon_size, waste_size, recycle_count}); end
    checks++; if ({busy, dp_start, dp_op, take_ack, take_nack, draw_nack, timeout_err} !== 8'd0) begin errors++; $display("FAIL reset_outputs: got %b want 0", {busy, dp_start, dp_op, take_ack, take_nack, draw_nack, timeout_err}); end
    rst = 1'b0;
    step();
    checks++; if (talon_size !== 5'd24 || waste_size !== 5'd0 || recycle_count !== 4'd0) begin errors++; $display("FAIL init_load: got t=%0d w=%0d r=%0d want 24/0/0", talon_size, waste_size, recycle_count); end
    checks++; if ({busy, dp_start, take_ack, take_nack, draw_nack, timeout_err} !== 6'd0) begin errors++; $display("FAIL init_idle: got %b want 0", {busy, dp_start, take_ack, take_nack, draw_nack, timeout_err}); end
    checks++; if (b_talon_size !== 5'd24) begin errors++; $display("FAIL init_load_lim: got %0d want 24", b_talon_size); end
  endtask

  task automatic test_draw();
    bit got;
    logic [1:0] op;
    int n, extra;
    draw_req = 1'b1;
    wait_start(got, op, n);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL draw_start: got %0d want 1", got); end
    checks++; if (op !== 2'd0) begin errors++; $display("FAIL draw_op: got %0d want 0", op); end
    checks++; if (n !== 2) begin errors++; $display("FAIL draw_latency: got %0d want 2", n); end
    finish_op();
    checks++; if (talon_size !== 5'd23 || waste_size !== 5'd1) begin errors++; $display("FAIL draw_counters: got t=%0d w=%0d want 23/1", talon_size, waste_size); end
    extra = 0;
    repeat (6) begin step(); if (dp_start) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL draw_level_no_redraw: got %0d starts want 0", extra); end
    draw_req = 1'b0;
    step();
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    step();
    checks++; if (talon_size !== 5'd23 || waste_size !== 5'd1 || busy !== 1'b0) begin errors++; $display("FAIL stray_done: got t=%0d w=%0d busy=%0d want 23/1/0", talon_size, waste_size, busy); end
  endtask

  task automatic test_priority();
    bit got;
    logic [1:0] op;
    int n;
    setup(5'd8);
    repeat (3) do_draw();
    checks++; if (talon_size !== 5'd5 || waste_size !== 5'd3) begin errors++; $display("FAIL prio_setup: got t=%0d w=%0d want 5/3", talon_size, waste_size); end
    take_req = 1'b1;
    draw_req = 1'b1;
    wait_start(got, op, n);
    checks++; if (got !== 1'b1 || op !== 2'd2) begin errors++; $display("FAIL prio_take_first: got start=%0d op=%0d want 1/2", got, op); end
    finish_op();
    checks++; if (take_ack !== 1'b1 || waste_size !== 5'd2 || talon_size !== 5'd5) begin errors++; $display("FAIL prio_take_ack: got ack=%0d t=%0d w=%0d want 1/5/2", take_ack, talon_size, waste_size); end
    take_req = 1'b0;
    step();
    checks++; if (dp_start !== 1'b1 || dp_op !== 2'd0) begin errors++; $display("FAIL prio_draw_next: got start=%0d op=%0d want 1/0", dp_start, dp_op); end
    checks++; if (take_ack !== 1'b0) begin errors++; $display("FAIL prio_ack_pulse: got %0d want 0", take_ack); end
    finish_op();
    checks++; if (talon_size !== 5'd4 || waste_size !== 5'd3) begin errors++; $display("FAIL prio_draw_counters: got t=%0d w=%0d want 4/3", talon_size, waste_size); end
    draw_req = 1'b0;
    step();
  endtask

  task automatic test_recycle();
    bit got;
    logic [1:0] op;
    int n;
    setup(5'd5);
    repeat (5) do_draw();
    checks++; if (talon_size !== 5'd0 || waste_size !== 5'd5) begin errors++; $display("FAIL recyc_setup: got t=%0d w=%0d want 0/5", talon_size, waste_size); end
    draw_req = 1'b1;
    wait_start(got, op, n);
    draw_req = 1'b0;
    checks++; if (got !== 1'b1 || op !== 2'd1) begin errors++; $display("FAIL recyc_op: got start=%0d op=%0d want 1/1", got, op); end
    finish_op();
    checks++; if (talon_size !== 5'd5 || waste_size !== 5'd0 || recycle_count !== 4'd1) begin errors++; $display("FAIL recyc_counters: got t=%0d w=%0d r=%0d want 5/0/1", talon_size, waste_size, recycle_count); end
    checks++; if (b_recycle_count !== 4'd1) begin errors++; $display("FAIL recyc_lim_first: got %0d want 1", b_recycle_count); end
    step();
    repeat (5) do_draw();
    draw_req = 1'b1;
    step();
    step();
    checks++; if (b_draw_nack !== 1'b1 || b_dp_start !== 1'b0) begin errors++; $display("FAIL recyc_limit_nack: got nack=%0d start=%0d want 1/0", b_draw_nack, b_dp_start); end
    checks++; if (dp_start !== 1'b1 || dp_op !== 2'd1) begin errors++; $display("FAIL recyc_unlimited_again: got start=%0d op=%0d want 1/1", dp_start, dp_op); end
    draw_req = 1'b0;
    step();
    checks++; if (b_draw_nack !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL recyc_limit_pulse: got nack=%0d busy=%0d want 0/0", b_draw_nack, b_busy); end
    step();
    dp_done = 1'b1;
    step();
    dp_done = 1'b0;
    checks++; if (talon_size !== 5'd5 || waste_size !== 5'd0 || recycle_count !== 4'd2) begin errors++; $display("FAIL recyc_second: got t=%0d w=%0d r=%0d want 5/0/2", talon_size, waste_size, recycle_count); end
    checks++; if (b_talon_size !== 5'd0 || b_waste_size !== 5'd5 || b_recycle_count !== 4'd1) begin errors++; $display("FAIL recyc_lim_hold: got t=%0d w=%0d r=%0d want 0/5/1", b_talon_size, b_waste_size, b_recycle_count); end
    step();
  endtask

  task automatic test_nack();
    setup(5'd0);
    take_req = 1'b1;
    step();
    checks++; if (take_nack !== 1'b1 || dp_start !== 1'b0) begin errors++; $display("FAIL take_nack: got nack=%0d start=%0d want 1/0", take_nack, dp_start); end
    take_req = 1'b0;
    step();
    checks++; if (take_nack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL take_nack_pulse: got nack=%0d busy=%0d want 0/0", take_nack, busy); end
    draw_req = 1'b1;
    step();
    step();
    checks++; if (draw_nack !== 1'b1 || dp_start !== 1'b0) begin errors++; $display("FAIL draw_nack_empty: got nack=%0d start=%0d want 1/0", draw_nack, dp_start); end
    draw_req = 1'b0;
    step();
    checks++; if (draw_nack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL draw_nack_pulse: got nack=%0d busy=%0d want 0/0", draw_nack, busy); end
  endtask

  task automatic test_timeout();
    bit got;
    logic [1:0] op;
    int n, cyc;
    setup(5'd30);
    checks++; if (talon_size !== 5'd24 || waste_size !== 5'd0) begin errors++; $display("FAIL setup_clamp: got t=%0d w=%0d want 24/0", talon_size, waste_size); end
    draw_req = 1'b1;
    wait_start(got, op, n);
    draw_req = 1'b0;
    cyc = 0;
    while (!timeout_err && cyc < 40) begin step(); cyc++; end
    checks++; if (cyc !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d want 16", cyc); end
    checks++; if (talon_size !== 5'd24 || waste_size !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_counters: got t=%0d w=%0d busy=%0d want 24/0/0", talon_size, waste_size, busy); end
    step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %0d want 0", timeout_err); end
    do_draw();
    take_req = 1'b1;
    wait_start(got, op, n);
    checks++; if (got !== 1'b1 || op !== 2'd2) begin errors++; $display("FAIL take_to_start: got start=%0d op=%0d want 1/2", got, op); end
    cyc = 0;
    while (!timeout_err && cyc < 40) begin step(); cyc++; end
    checks++; if (cyc !== 16 || take_nack !== 1'b1 || take_ack !== 1'b0) begin errors++; $display("FAIL take_timeout: got cyc=%0d nack=%0d ack=%0d want 16/1/0", cyc, take_nack, take_ack); end
    take_req = 1'b0;
    checks++; if (talon_size !== 5'd23 || waste_size !== 5'd1) begin errors++; $display("FAIL take_timeout_counters: got t=%0d w=%0d want 23/1", talon_size, waste_size); end
    step();
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [1:0] op;
    int n, acks;
    take_req = 1'b1;
    wait_start(got, op, n);
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0d want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({talon_size, waste_size, recycle_count} !== 14'd0 || {busy, dp_start, dp_op, take_ack, take_nack, draw_nack, timeout_err} !== 8'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h/%b want 0/0", {talon_size, waste_size, recycle_count}, {busy, dp_start, dp_op, take_ack, take_nack, draw_nack, timeout_err}); end
    take_req = 1'b0;
    dp_done  = 1'b1;
    acks = 0;
    repeat (3) begin step(); if (take_ack || take_nack) acks++; end
    dp_done = 1'b0;
    rst = 1'b0;
    checks++; if (acks !== 0 || busy !== 1'b0 || talon_size !== 5'd0) begin errors++; $display("FAIL mid_no_ack: got acks=%0d busy=%0d t=%0d want 0/0/0", acks, busy, talon_size); end
    step();
    checks++; if (talon_size !== 5'd24 || waste_size !== 5'd0) begin errors++; $display("FAIL mid_reinit: got t=%0d w=%0d want 24/0", talon_size, waste_size); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_draw();
    test_priority();
    test_recycle();
    test_nack();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
